uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_defs.sv | 12 +
 rtl/uart_arb_pick.sv | 31 +++
 rtl/uart_tx_arb.sv | 131 +++++++++++++
 tb/tb_uart_tx_arb.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// Shared definitions for the UART transmit arbiter: FSM state type and
// the default burst length.
package uart_defs;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } ArbState_t;

  localparam int MAX_BURST_DEF = 16;

endpackage

// File: rtl/uart_arb_pick.sv
// Combinational winner picker: scans the request vector starting at a
// given index, wrapping around, and reports the first hit.
module uart_arb_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         valid
);

  int j;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    j      = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(start) + i) % N;
      if (!valid && req[j]) begin
        valid     = 1'b1;
        idx       = W'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Multiplexes NUM_REQ byte streams into one UART transmitter in bursts.
// Define UART_TX_ARB_PRIO_EN for fixed priority (lowest index wins);
// otherwise arbitration is round-robin.
module uart_tx_arb
  import uart_defs::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [8*NUM_REQ-1:0]       req_data_i,
  input  logic [NUM_REQ-1:0]         req_last_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [7:0]                 tx_d_o,
  output logic                       tx_d_valid_o,
  input  logic                       tx_d_ready_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic                       busy_o
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  ArbState_t        state, state_nxt;
  logic [GW-1:0]    grant;
  logic [NUM_REQ-1:0] grant_oh;
  logic [CW-1:0]    cnt;
  logic [GW-1:0]    start;
  logic [NUM_REQ-1:0] pick_oh;
  logic [GW-1:0]    pick_idx;
  logic             pick_valid;
  logic             slot_free;
  logic             accept;
  logic             burst_end;

  uart_arb_pick #(.N(NUM_REQ), .W(GW)) u_pick (
    .req    (req_valid_i),
    .start  (start),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

`ifdef UART_TX_ARB_PRIO_EN
  assign start = '0;
`else
  logic [GW-1:0] rr_ptr;

  // Pointer moves just past the owner whenever a burst finishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (burst_end) begin
      rr_ptr <= (grant == GW'(NUM_REQ - 1)) ? '0 : grant + GW'(1);
    end
  end

  assign start = rr_ptr;
`endif

  // The output register can take a byte when empty or being drained now.
  assign slot_free = ~tx_d_valid_o | tx_d_ready_i;
  assign accept    = (state == BURST) & (|(req_valid_i & grant_oh)) & slot_free;
  assign burst_end = accept & ((|(req_last_i & grant_oh)) | (cnt == CW'(MAX_BURST - 1)));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-requester ready.
  always_comb begin
    state_nxt   = state;
    req_ready_o = '0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt = BURST;
        end else begin
          state_nxt = IDLE;
        end
      end
      BURST: begin
        req_ready_o = grant_oh & {NUM_REQ{slot_free}};
        if (burst_end) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = BURST;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Grant capture, burst counting and the transmit holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant        <= '0;
      grant_oh     <= '0;
      cnt          <= '0;
      tx_d_o       <= 8'h00;
      tx_d_valid_o <= 1'b0;
    end else begin
      if (state == IDLE && pick_valid) begin
        grant    <= pick_idx;
        grant_oh <= pick_oh;
        cnt      <= '0;
      end else if (accept) begin
        cnt <= cnt + CW'(1);
      end
      if (accept) begin
        tx_d_o       <= req_data_i[8*grant +: 8];
        tx_d_valid_o <= 1'b1;
      end else if (tx_d_ready_i) begin
        tx_d_valid_o <= 1'b0;
      end
    end
  end

  assign grant_id_o = grant;
  assign busy_o     = (state == BURST);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: queued byte sources, a transaction-level
// arbitration model, and an independent monitor checking handshakes and bytes.
module tb_uart_tx_arb;

  localparam int N  = 4;
  localparam int MB = 16;
  localparam int GW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     req_last;
  logic [N-1:0]     req_ready;
  logic [7:0]       tx_d;
  logic             tx_valid;
  logic             tx_ready;
  logic [GW-1:0]    grant_id;
  logic             busy;

  uart_tx_arb #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_last_i   (req_last),
    .req_ready_o  (req_ready),
    .tx_d_o       (tx_d),
    .tx_d_valid_o (tx_valid),
    .tx_d_ready_i (tx_ready),
    .grant_id_o   (grant_id),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t      srcq[N][$];
  int         sent[N];
  int         exp_src[$];
  logic [7:0] exp_byte[$];
  int         out_cyc[$];
  int         model_ptr = 0;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         gap_en = 1'b0;
  int         ready_mode = 1;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push_byte(input int k, input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    srcq[k].push_back(b);
  endtask

  // Transaction-level reference: whole bursts granted in arbitration order.
  function automatic void build_model();
    beat_t q[N][$];
    int    g;
    int    n;
    bit    found;
    bit    done;
    bit    more;
    for (int k = 0; k < N; k++) q[k] = srcq[k];
    more = 1'b1;
    while (more) begin
      found = 1'b0;
      g = 0;
      for (int i = 0; i < N; i++) begin
        int j;
        j = (model_ptr + i) % N;
        if (!found && q[j].size() > 0) begin
          found = 1'b1;
          g = j;
        end
      end
      if (!found) begin
        more = 1'b0;
      end else begin
        n = 0;
        done = 1'b0;
        while (!done) begin
          beat_t b;
          b = q[g].pop_front();
          exp_src.push_back(g);
          exp_byte.push_back(b.d);
          n++;
          done = b.l || (n == MB) || (q[g].size() == 0);
        end
`ifndef UART_TX_ARB_PRIO_EN
        model_ptr = (g + 1) % N;
`endif
      end
    end
  endfunction

  // Source driver: retire accepted bytes, then present the next ones.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b0;
    forever begin
      logic [N-1:0] acc;
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (acc[k] && srcq[k].size() > 0) begin
          if (srcq[k][0].l) sent[k] = 0;
          else sent[k] = sent[k] + 1;
          void'(srcq[k].pop_front());
        end
      end
      for (int k = 0; k < N; k++) begin
        bit g;
        g = gap_en && (sent[k] % MB != 0) && ($urandom_range(0, 2) == 0);
        if (srcq[k].size() > 0 && !g) begin
          req_valid[k]      = 1'b1;
          req_data[8*k +: 8] = srcq[k][0].d;
          req_last[k]       = srcq[k][0].l;
        end else begin
          req_valid[k]      = 1'b0;
          req_data[8*k +: 8] = 8'($urandom);
          req_last[k]       = 1'($urandom);
        end
      end
      case (ready_mode)
        0:       tx_ready = 1'($urandom_range(0, 1));
        1:       tx_ready = 1'b1;
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // Monitor: ownership, ready rule, acceptance order, output bytes, hold.
  logic [7:0] prev_d;
  bit         prev_hold = 1'b0;

  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(tx_valid), 32'd1);
        check("hold_data", 32'(tx_d), 32'(prev_d));
      end
      exp_rdy = '0;
      if (busy) begin
        if (exp_src.size() == 0) begin
          check("spurious_busy", 32'(busy), 32'd0);
        end else begin
          check("grant_id", 32'(grant_id), 32'(exp_src[0]));
          exp_rdy[exp_src[0]] = !tx_valid || tx_ready;
        end
      end
      check("ready_rule", 32'(req_ready), 32'(exp_rdy));
      if ((req_valid & req_ready) != '0 && exp_src.size() > 0) void'(exp_src.pop_front());
      if (tx_valid && tx_ready) begin
        if (exp_byte.size() == 0) begin
          check("unexpected_byte", 32'(tx_d), 32'hFFFF_FFFF);
        end else begin
          check("tx_byte", 32'(tx_d), 32'(exp_byte[0]));
          void'(exp_byte.pop_front());
        end
        out_cyc.push_back(cyc);
      end
      prev_hold = tx_valid && !tx_ready;
      prev_d    = tx_d;
    end
  end

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk);
      ok = (exp_byte.size() == 0) && !busy;
      for (int k = 0; k < N; k++) if (srcq[k].size() != 0) ok = 1'b0;
    end
    #2;
    check({name, "_done"}, 32'(ok), 32'd1);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_valid"}, 32'(tx_valid), 32'd0);
    check({name, "_data"}, 32'(tx_d), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_grant"}, 32'(grant_id), 32'd0);
    check({name, "_ready"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    #1;
    check_zero_outputs("reset");
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    // Single requester, three-byte packet, back-to-back output.
    out_cyc.delete();
    push_byte(2, 8'hA1, 1'b0);
    push_byte(2, 8'hA2, 1'b0);
    push_byte(2, 8'hA3, 1'b1);
    build_model();
    wait_done("single");
    check("busy_after_last", 32'(busy), 32'd0);
    check("out_count", 32'(out_cyc.size()), 32'd3);
    if (out_cyc.size() == 3) check("back_to_back", 32'(out_cyc[2] - out_cyc[0]), 32'd2);

    // Every requester with one-byte packets.
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < N; k++) push_byte(k, 8'(16 * k + p), 1'b1);
    build_model();
    wait_done("rr_single");

    // Long packet split at the burst limit, alone and with a competitor.
    for (int i = 0; i < 20; i++) push_byte(1, 8'(8'h40 + i), (i == 19));
    build_model();
    wait_done("long_alone");
    for (int i = 0; i < 20; i++) push_byte(1, 8'(8'h80 + i), (i == 19));
    push_byte(2, 8'hC0, 1'b0);
    push_byte(2, 8'hC1, 1'b1);
    build_model();
    wait_done("long_shared");

    // Transmitter stalled with a byte buffered.
    ready_mode = 2;
    push_byte(3, 8'h55, 1'b0);
    push_byte(3, 8'h66, 1'b1);
    build_model();
    repeat (6) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_data", 32'(tx_d), 32'h55);
      check("stall_valid", 32'(tx_valid), 32'd1);
      check("stall_ready", 32'(req_ready[3]), 32'd0);
    end
    @(posedge clk);
    #2;
    ready_mode = 1;
    wait_done("stall");

    // Randomised traffic with transmitter back-pressure and owner gaps.
    gap_en = 1'b1;
    ready_mode = 0;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < N; k++) begin
        int npk;
        npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++) begin
          int len;
          len = $urandom_range(1, 20);
          for (int i = 0; i < len; i++) push_byte(k, 8'($urandom), (i == len - 1));
        end
      end
      build_model();
      wait_done("random");
    end
    gap_en = 1'b0;
    ready_mode = 1;

    // Move the pointer off zero, then reset in the middle of a burst.
    push_byte(2, 8'h22, 1'b1);
    build_model();
    wait_done("pre_reset");
    for (int i = 0; i < 4; i++) push_byte(0, 8'(8'hD0 + i), (i == 3));
    build_model();
    for (int i = 0; i < 50 && exp_src.size() > 3; i++) @(posedge clk);
    @(posedge clk);
    #2;
    check("reset_mid_burst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_zero_outputs("mid_reset");
    for (int k = 0; k < N; k++) begin
      srcq[k].delete();
      sent[k] = 0;
    end
    exp_src.delete();
    exp_byte.delete();
    model_ptr = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check_zero_outputs("post_reset");
    for (int k = 0; k < N; k++) push_byte(k, 8'(8'hE0 + k), 1'b1);
    build_model();
    wait_done("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
